// File: rtl/ps2_host_rx.sv
// PS/2 host receiver: synchroniser and clock filter, 11-bit frame deframer, result FIFO.
// Build option PS2_RX_BREAK_DECODE_EN folds E0/F0 prefix bytes into per-entry flags.
module ps2_host_rx #(
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned TIMEOUT_CYC = 10000,
    parameter int unsigned FIFO_BITS   = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_release,
    output logic       rx_extended,
    output logic       rx_parity_err,
    output logic       rx_frame_err,
    output logic       rx_overflow
);
`ifdef PS2_RX_BREAK_DECODE_EN
    localparam int unsigned ENTRY_W = 10;
`else
    localparam int unsigned ENTRY_W = 8;
`endif
    localparam int unsigned DEPTH = 1 << FIFO_BITS;
    localparam int unsigned PW    = FIFO_BITS + 1;
    localparam int unsigned TW    = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned FW    = $clog2(FILTER_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic          clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
    logic          filt_clk_q, filt_clk_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          fall;
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          good_byte;
    logic          perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] wr_entry, head;
    logic          push, pop, full, empty, do_write;

    // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it
    always_comb begin
        filt_clk_d = filt_clk_q;
        filt_cnt_d = '0;
        if (clk_sync_q != filt_clk_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) filt_clk_d = clk_sync_q;
            else filt_cnt_d = filt_cnt_q + FW'(1);
        end
    end
    assign fall = filt_clk_q & ~filt_clk_d;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        tmo_d     = '0;
        good_byte = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        if (fall) begin
            case (state_q)
                S_IDLE: if (!data_sync_q) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
                S_DATA: begin
                    shreg_d   = {data_sync_q, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = data_sync_q;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (!data_sync_q) ferr_d = 1'b1;
                    else if (!(^{shreg_q, par_q})) perr_d = 1'b1;
                    else good_byte = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                state_d = S_IDLE;
                ferr_d  = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

`ifdef PS2_RX_BREAK_DECODE_EN
    logic pend_rel_q, pend_rel_d, pend_ext_q, pend_ext_d;

    // Prefix bytes only set flags; the next real byte carries and clears them
    always_comb begin
        pend_rel_d = pend_rel_q;
        pend_ext_d = pend_ext_q;
        push       = 1'b0;
        wr_entry   = {pend_rel_q, pend_ext_q, shreg_q};
        if (perr_d || ferr_d) begin
            pend_rel_d = 1'b0;
            pend_ext_d = 1'b0;
        end else if (good_byte) begin
            if (shreg_q == 8'hE0) pend_ext_d = 1'b1;
            else if (shreg_q == 8'hF0) pend_rel_d = 1'b1;
            else begin
                push       = 1'b1;
                pend_rel_d = 1'b0;
                pend_ext_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_rel_q <= 1'b0;
            pend_ext_q <= 1'b0;
        end else begin
            pend_rel_q <= pend_rel_d;
            pend_ext_q <= pend_ext_d;
        end
    end

    assign rx_release  = rx_valid & head[9];
    assign rx_extended = rx_valid & head[8];
`else
    assign push        = good_byte;
    assign wr_entry    = shreg_q;
    assign rx_release  = 1'b0;
    assign rx_extended = 1'b0;
`endif

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[FIFO_BITS] != rd_ptr_q[FIFO_BITS]) &&
                      (wr_ptr_q[FIFO_BITS-1:0] == rd_ptr_q[FIFO_BITS-1:0]);
    assign pop      = ~empty & rx_ready;
    // A pop in the same cycle frees the slot the write lands in
    assign do_write = push & (~full | pop);
    assign ovf_d    = push & full & ~pop;
    assign wr_ptr_d = wr_ptr_q + PW'(do_write);
    assign rd_ptr_d = rd_ptr_q + PW'(pop);

    assign head          = mem_q[rd_ptr_q[FIFO_BITS-1:0]];
    assign rx_valid      = ~empty;
    assign rx_data       = rx_valid ? head[7:0] : '0;
    assign rx_parity_err = perr_q;
    assign rx_frame_err  = ferr_q;
    assign rx_overflow   = ovf_q;

    always_ff @(posedge clk) begin
        if (do_write) mem_q[wr_ptr_q[FIFO_BITS-1:0]] <= wr_entry;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            filt_clk_q  <= 1'b1;
            filt_cnt_q  <= '0;
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            clk_meta_q  <= ps2_clk;
            clk_sync_q  <= clk_meta_q;
            data_meta_q <= ps2_data;
            data_sync_q <= data_meta_q;
            filt_clk_q  <= filt_clk_d;
            filt_cnt_q  <= filt_cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end
endmodule

// File: tb/tb_ps2_host_rx.sv
// Self-checking bench for ps2_host_rx: frame table, hand-written corner sequences, random frames
// checked against a queue-based model of the receiver's byte stream.
module tb_ps2_host_rx;
    localparam int HALF  = 20;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset_n, ps2_clk, ps2_data, rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_release, rx_extended, rx_parity_err, rx_frame_err, rx_overflow;

    ps2_host_rx #(.FILTER_LEN(4), .TIMEOUT_CYC(200), .FIFO_BITS(3)) dut (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_release(rx_release), .rx_extended(rx_extended),
        .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err), .rx_overflow(rx_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    int perr_seen = 0, ferr_seen = 0, ovf_seen = 0, pops_seen = 0, valid_cyc = 0;
    int exp_perr = 0, exp_ferr = 0, exp_ovf = 0;
    logic [9:0] exp_q[$];
    bit m_rel = 1'b0, m_ext = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Expected outcome of one frame, decided before it is sent
    task automatic model_frame(input logic [7:0] b, input bit bp, input bit bs, input bit pop_same);
        logic [9:0] ent;
        if (bs) begin
            exp_ferr++; m_rel = 1'b0; m_ext = 1'b0;
        end else if (bp) begin
            exp_perr++; m_rel = 1'b0; m_ext = 1'b0;
        end else begin
`ifdef PS2_RX_BREAK_DECODE_EN
            if (b == 8'hE0) begin m_ext = 1'b1; return; end
            if (b == 8'hF0) begin m_rel = 1'b1; return; end
            ent = {m_rel, m_ext, b};
            m_rel = 1'b0; m_ext = 1'b0;
`else
            ent = {2'b00, b};
`endif
            if (exp_q.size() < DEPTH || pop_same) exp_q.push_back(ent);
            else exp_ovf++;
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (rx_parity_err) perr_seen++;
            if (rx_frame_err) ferr_seen++;
            if (rx_overflow) ovf_seen++;
            if (rx_valid) valid_cyc++;
            if (rx_valid && rx_ready) begin
                pops_seen++;
                if (exp_q.size() == 0) chk("pop_with_model_empty", 32'(rx_valid), 32'd0);
                else chk("pop_entry", {rx_release, rx_extended, rx_data}, exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Device drives data while clock is high; pop_same raises rx_ready for the single
    // cycle in which the falling edge is processed (2 sync stages + 4 filter samples)
    task automatic send_bit(input bit d, input bit pop_same);
        ps2_data = d;
        cyc(HALF / 2);
        ps2_clk = 1'b0;
        if (pop_same) begin
            cyc(5); rx_ready = 1'b1; cyc(1); rx_ready = 1'b0; cyc(HALF - 6);
        end else begin
            cyc(HALF);
        end
        ps2_clk = 1'b1;
        cyc(HALF / 2);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bp, input bit bs, input bit pop_same);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
        send_bit((~^b) ^ bp, 1'b0);
        send_bit(~bs, pop_same);
        ps2_data = 1'b1;
        cyc(2 * HALF);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         bp;
        bit         bs;
        int         exp_good;
        int         exp_perr;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int p, v, pe, fe, ov;
        logic [7:0] rb;
        bit rp, rs;
        reset_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {rx_valid, rx_data, rx_release, rx_extended,
                              rx_parity_err, rx_frame_err, rx_overflow}, 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        cyc(5);

        vecs[0] = '{8'h1C, 1'b0, 1'b0, 1, 0, 0};
        vecs[1] = '{8'h5A, 1'b1, 1'b0, 0, 1, 0};
        vecs[2] = '{8'h5A, 1'b0, 1'b0, 1, 0, 0};
        vecs[3] = '{8'h29, 1'b0, 1'b1, 0, 0, 1};
        vecs[4] = '{8'h29, 1'b1, 1'b1, 0, 0, 1};
        vecs[5] = '{8'h00, 1'b0, 1'b0, 1, 0, 0};
        vecs[6] = '{8'hFF, 1'b0, 1'b0, 1, 0, 0};
        for (int i = 0; i < 7; i++) begin
            p = pops_seen; v = valid_cyc; pe = perr_seen; fe = ferr_seen; ov = ovf_seen;
            model_frame(vecs[i].data, vecs[i].bp, vecs[i].bs, 1'b0);
            send_frame(vecs[i].data, vecs[i].bp, vecs[i].bs, 1'b0);
            chk($sformatf("vec%0d_pops", i), pops_seen - p, vecs[i].exp_good);
            chk($sformatf("vec%0d_valid_cycles", i), valid_cyc - v, vecs[i].exp_good);
            chk($sformatf("vec%0d_parity_err", i), perr_seen - pe, vecs[i].exp_perr);
            chk($sformatf("vec%0d_frame_err", i), ferr_seen - fe, vecs[i].exp_ferr);
            chk($sformatf("vec%0d_overflow", i), ovf_seen - ov, 0);
        end

        // Timeout: start bit plus three data bits, then silence
        fe = ferr_seen;
        send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        ps2_data = 1'b1;
        cyc(300);
        exp_ferr++; m_rel = 1'b0; m_ext = 1'b0;
        chk("timeout_frame_err", ferr_seen - fe, 1);
        p = pops_seen;
        model_frame(8'h29, 1'b0, 1'b0, 1'b0);
        send_frame(8'h29, 1'b0, 1'b0, 1'b0);
        chk("after_timeout_rx", pops_seen - p, 1);

        // Fill, overflow on the ninth, then push+pop in the same cycle while full
        rx_ready = 1'b0;
        ov = ovf_seen;
        for (int i = 1; i <= 9; i++) begin
            model_frame(8'(i), 1'b0, 1'b0, 1'b0);
            send_frame(8'(i), 1'b0, 1'b0, 1'b0);
        end
        chk("fill_overflow", ovf_seen - ov, 1);
        chk("fill_valid", 32'(rx_valid), 32'd1);
        ov = ovf_seen;
        model_frame(8'h0A, 1'b0, 1'b0, 1'b1);
        send_frame(8'h0A, 1'b0, 1'b0, 1'b1);
        chk("full_push_pop_overflow", ovf_seen - ov, 0);
        p = pops_seen;
        rx_ready = 1'b1;
        cyc(30);
        chk("full_drain_count", pops_seen - p, 8);
        chk("drained_valid", 32'(rx_valid), 32'd0);

        // Prefix stream
        rx_ready = 1'b0;
        model_frame(8'hE0, 1'b0, 1'b0, 1'b0); send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
        model_frame(8'hF0, 1'b0, 1'b0, 1'b0); send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        model_frame(8'h75, 1'b0, 1'b0, 1'b0); send_frame(8'h75, 1'b0, 1'b0, 1'b0);
        model_frame(8'h75, 1'b0, 1'b0, 1'b0); send_frame(8'h75, 1'b0, 1'b0, 1'b0);
        p = pops_seen;
        rx_ready = 1'b1;
        cyc(10);
`ifdef PS2_RX_BREAK_DECODE_EN
        chk("prefix_entries", pops_seen - p, 2);
`else
        chk("prefix_entries", pops_seen - p, 4);
`endif

        // Reset mid-frame with a byte waiting; remaining bits of the 0xFF frame are all ones
        rx_ready = 1'b0;
        model_frame(8'h33, 1'b0, 1'b0, 1'b0); send_frame(8'h33, 1'b0, 1'b0, 1'b0);
        chk("pre_reset_valid", 32'(rx_valid), 32'd1);
        send_bit(1'b0, 1'b0);
        repeat (4) send_bit(1'b1, 1'b0);
        reset_n = 1'b0;
        exp_q.delete(); m_rel = 1'b0; m_ext = 1'b0;
        cyc(3);
        chk("mid_frame_reset_outputs", {rx_valid, rx_data, rx_release, rx_extended,
                                        rx_parity_err, rx_frame_err, rx_overflow}, 32'd0);
        reset_n = 1'b1; rx_ready = 1'b1;
        cyc(2);
        p = pops_seen; pe = perr_seen; fe = ferr_seen;
        repeat (6) send_bit(1'b1, 1'b0);
        cyc(2 * HALF);
        chk("tail_ignored", (pops_seen - p) + (perr_seen - pe) + (ferr_seen - fe), 0);
        model_frame(8'h6B, 1'b0, 1'b0, 1'b0); send_frame(8'h6B, 1'b0, 1'b0, 1'b0);
        chk("post_reset_rx", pops_seen - p, 1);

        // Random frames
        for (int i = 0; i < 24; i++) begin
            rb = 8'($urandom_range(0, 255));
            rp = ($urandom_range(0, 7) == 0);
            rs = ($urandom_range(0, 7) == 0);
            model_frame(rb, rp, rs, 1'b0);
            send_frame(rb, rp, rs, 1'b0);
            chk($sformatf("rand%0d_pending", i), exp_q.size(), 0);
        end

        chk("total_parity_err", perr_seen, exp_perr);
        chk("total_frame_err", ferr_seen, exp_ferr);
        chk("total_overflow", ovf_seen, exp_ovf);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end
endmodule
